irq_timer: RTL

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/cpu_params_pkg.sv | 24 ++
 rtl/sync_flops.sv | 25 ++
 rtl/irq_timer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_params_pkg.sv
// Shared constants for the machine timer / interrupt block: register offsets,
// time width and the mtimecmp reset value.
package cpu_params_pkg;

  localparam int DATA_W = 32;
  localparam int TIME_W = 64;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_MSIP        = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_LO = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_HI = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_MTIME_LO    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_MTIME_HI    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE    = 3'd5;

  // All-ones keeps the timer interrupt quiet until software programs a compare value
  localparam logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Offsets above prescale have no register behind them
  function automatic logic isMapped(input logic [ADDR_W-1:0] addr);
    return (addr <= ADDR_PRESCALE);
  endfunction

endpackage

// File: rtl/sync_flops.sv
// Multi-flop synchronizer for an asynchronous level input. DEPTH must be at
// least 2 so the first flop has a full cycle to resolve metastability.
module sync_flops #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic i_async,
  output logic o_sync
);

  logic [DEPTH-1:0] r_stages;

  // Shift the raw level through the flop chain; reset clears every stage
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_stages[DEPTH-1];

endmodule

// File: rtl/irq_timer.sv
// Machine timer and interrupt source block: a small register bus exposing
// msip, mtime, mtimecmp and a prescaler, plus a synchronized external IRQ.
import cpu_params_pkg::*;

module irq_timer #(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] PRESC_RST   = 32'd0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  input  logic              ext_irq_raw,
  output logic              ext_irq,
  output logic              mtip,
  output logic              msip
);

  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busErr;
  logic              r_msip;
  logic              r_mtip;
  logic [TIME_W-1:0] r_mtime;
  logic [TIME_W-1:0] r_mtimecmp;
  logic [DATA_W-1:0] r_prescale;
  logic [DATA_W-1:0] r_prescCnt;

  logic              w_accept;
  logic              w_write;
  logic              w_read;
  logic              w_wrMsip;
  logic              w_wrCmpLo;
  logic              w_wrCmpHi;
  logic              w_wrTimeLo;
  logic              w_wrTimeHi;
  logic              w_wrPresc;
  logic              w_tick;
  logic [DATA_W-1:0] w_readData;

  // A request is taken only while no ack is outstanding, so a request held
  // through the ack cycle is not mistaken for a second transaction.
  assign w_accept   = req & ~r_ack;
  assign w_write    = w_accept & we;
  assign w_read     = w_accept & ~we;
  assign w_wrMsip   = w_write && (addr == ADDR_MSIP);
  assign w_wrCmpLo  = w_write && (addr == ADDR_MTIMECMP_LO);
  assign w_wrCmpHi  = w_write && (addr == ADDR_MTIMECMP_HI);
  assign w_wrTimeLo = w_write && (addr == ADDR_MTIME_LO);
  assign w_wrTimeHi = w_write && (addr == ADDR_MTIME_HI);
  assign w_wrPresc  = w_write && (addr == ADDR_PRESCALE);

  // The tick is decided from the counter and prescale as they stand before
  // the edge; a prescale write only restarts the count from zero.
  assign w_tick = (r_prescCnt == r_prescale);

  // Read mux over the current register contents; unmapped offsets read as 0
  always_comb begin
    w_readData = '0;
    case (addr)
      ADDR_MSIP:        w_readData = {{(DATA_W-1){1'b0}}, r_msip};
      ADDR_MTIMECMP_LO: w_readData = r_mtimecmp[DATA_W-1:0];
      ADDR_MTIMECMP_HI: w_readData = r_mtimecmp[TIME_W-1:DATA_W];
      ADDR_MTIME_LO:    w_readData = r_mtime[DATA_W-1:0];
      ADDR_MTIME_HI:    w_readData = r_mtime[TIME_W-1:DATA_W];
      ADDR_PRESCALE:    w_readData = r_prescale;
      default:          w_readData = '0;
    endcase
  end

  // Bus response: one-cycle ack, read data captured at acceptance, error flag
  // for unmapped offsets. Data is zero whenever ack is low.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_busErr <= 1'b0;
    end else begin
      r_ack    <= w_accept;
      r_rdata  <= w_read ? w_readData : '0;
      r_busErr <= w_accept && !isMapped(addr);
    end
  end

  // Software interrupt bit; only bit 0 of the write data is kept
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_msip <= 1'b0;
    end else if (w_wrMsip) begin
      r_msip <= wdata[0];
    end
  end

  // Prescale register and its 0..prescale counter; writing prescale restarts the count
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_prescale <= PRESC_RST;
      r_prescCnt <= '0;
    end else begin
      if (w_wrPresc) begin
        r_prescale <= wdata;
      end
      if (w_wrPresc || w_tick) begin
        r_prescCnt <= '0;
      end else begin
        r_prescCnt <= r_prescCnt + 32'd1;
      end
    end
  end

  // mtime: a bus write to either half wins over the tick on that edge, so no
  // carry can ripple into the half that was not written.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_mtime <= '0;
    end else if (w_wrTimeLo) begin
      r_mtime[DATA_W-1:0] <= wdata;
    end else if (w_wrTimeHi) begin
      r_mtime[TIME_W-1:DATA_W] <= wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp halves are written independently
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_mtimecmp <= MTIMECMP_RST;
    end else if (w_wrCmpLo) begin
      r_mtimecmp[DATA_W-1:0] <= wdata;
    end else if (w_wrCmpHi) begin
      r_mtimecmp[TIME_W-1:DATA_W] <= wdata;
    end
  end

  // Timer interrupt compares the registered values, so it trails them by one cycle
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  sync_flops #(
    .DEPTH (SYNC_STAGES)
  ) u_extSync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_async  (ext_irq_raw),
    .o_sync   (ext_irq)
  );

  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign bus_err = r_busErr;
  assign mtip    = r_mtip;
  assign msip    = r_msip;

endmodule
